// File: rtl/booth_seq_multiplier_pkg.sv
// Shared definitions for the sequential multiply (and future divide) sequencers:
// state encodings, word width and Booth action codes.
package booth_seq_multiplier_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
        case ({q0, q_1})
            2'b01:   return BOOTH_ADD;
            2'b10:   return BOOTH_SUB;
            default: return BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_seq_multiplier_booth_step.sv
// One radix-2 Booth iteration: add/subtract M into A, then arithmetic shift
// of {A, Q, q_1} right by one.
module booth_step
    import booth_seq_multiplier_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_1_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc;
        case (booth_decode(q[0], q_1))
            BOOTH_ADD: sum = acc + m;
            BOOTH_SUB: sum = acc - m;
            default:   sum = acc;
        endcase
        acc_next = {sum[WIDTH], sum[WIDTH:1]};
        q_next   = {sum[0], q[WIDTH-1:1]};
        q_1_next = q[0];
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Multi-cycle signed Booth multiplier: one iteration per clock, product
// returned in hi/lo and held until the next completed operation.
module booth_seq_multiplier
    import booth_seq_multiplier_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    state_t           state, state_next;
    logic [WIDTH:0]   acc, m;
    logic [WIDTH-1:0] q;
    logic             q_1;
    logic [CNT_W-1:0] count;
    logic             load, last;

    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] q_next;
    logic             q_1_next;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .q        (q),
        .q_1      (q_1),
        .m        (m),
        .acc_next (acc_next),
        .q_next   (q_next),
        .q_1_next (q_1_next)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        last       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (count == LAST_COUNT) begin
                    last       = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // hi/lo only move when an operation completes, so they survive a following RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            acc   <= '0;
            q     <= '0;
            q_1   <= 1'b0;
            m     <= '0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (load) begin
            acc   <= '0;
            q     <= multiplier;
            q_1   <= 1'b0;
            m     <= {multiplicand[WIDTH-1], multiplicand};
            count <= '0;
        end else if (state == ST_RUN) begin
            acc   <= acc_next;
            q     <= q_next;
            q_1   <= q_1_next;
            count <= count + CNT_W'(1);
            if (last) begin
                hi <= acc_next[WIDTH-1:0];
                lo <= q_next;
            end
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed-vector bench for booth_seq_multiplier with hand-computed products.
module tb_booth_seq_multiplier;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks;
    int          n_fails;
    logic [63:0] mid_prod;
    int          done_pulses;

    booth_seq_multiplier dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge, in IDLE or DONE. Ends #1 after the edge that raises done.
    // Optionally re-pulses start with junk operands at cycle busy_pulse (0 = never).
    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int busy_pulse);
        int cyc;
        int busy_cnt;
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        step();
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        cyc          = 1;
        busy_cnt     = 0;
        done_pulses  = 0;
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            if (cyc == 16) mid_prod = {hi, lo};
            if (cyc == busy_pulse) begin
                start        = 1'b1;
                multiplicand = 32'd9;
                multiplier   = 32'd9;
            end
            step();
            start = 1'b0;
            cyc++;
        end
        if (done) done_pulses++;
        check({tag, " latency"}, 64'(cyc), 64'd33);
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'd32);
        check({tag, " product"}, {hi, lo}, exp);
        check({tag, " busy in done"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        mid_prod     = '0;
        done_pulses  = 0;
        reset        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        step();
        step();
        check("reset outputs", {busy, done, hi, lo}, 66'd0);
        reset = 1'b0;
        step();

        do_mul("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 0);
        check("3x5 hold from reset", mid_prod, 64'd0);
        step();
        check("done one cycle", {63'd0, done}, 64'd0);

        do_mul("-7x3", 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB, 0);
        step();
        do_mul("-1x-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 0);
        step();
        do_mul("min x min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0);
        step();
        do_mul("max x min", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 0);
        check("hold prev during run", mid_prod, 64'h4000_0000_0000_0000);
        step();
        do_mul("0 x min", 32'd0, 32'h8000_0000, 64'd0, 0);
        step();

        // Second start while busy must be ignored
        do_mul("busy start", 32'd2, 32'd2, 64'd4, 10);
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) done_pulses++;
        end
        check("busy start single done", 64'(done_pulses), 64'd1);
        check("busy start idle", {63'd0, busy}, 64'd0);

        // Back-to-back: second start issued during the DONE cycle
        do_mul("b2b first", 32'hFFFF_FFF9, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB, 0);
        do_mul("b2b second", 32'd6, 32'd7, 64'd42, 0);
        check("b2b hold prev", mid_prod, 64'hFFFF_FFFF_FFFF_FFEB);
        step();

        // Reset in the middle of a run
        start        = 1'b1;
        multiplicand = 32'd100;
        multiplier   = 32'd100;
        step();
        start = 1'b0;
        for (int i = 0; i < 14; i++) step();
        check("mid busy before reset", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        step();
        check("mid reset outputs", {busy, done, hi, lo}, 66'd0);
        reset       = 1'b0;
        done_pulses = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || busy) done_pulses++;
        end
        check("no done after abort", 64'(done_pulses), 64'd0);
        do_mul("after reset", 32'd100, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FF38, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/booth_seq_multiplier.md
Name: booth_seq_multiplier

Overview:
Multi-cycle signed (two's-complement) multiplier controller for the CPU's MUL instruction, executing radix-2 Booth recoding one bit per clock instead of in a single combinational pass. It latches operands on a start pulse, sequences WIDTH add/subtract-and-shift iterations, and returns a 2*WIDTH product split into HI/LO for the HI and LO registers. The control unit holds the MUL step until done is asserted.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH.
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
multiplicand  input  WIDTH  M operand (signed), sampled with start.
multiplier  input  WIDTH  Q operand (signed), sampled with start.
busy  output  1  high while iterating (RUN state).
done  output  1  one-cycle pulse; product valid.
hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH].
lo  output  WIDTH  product bits [WIDTH-1:0].

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. Reset takes priority over all other inputs.
- Reset values: state=IDLE, busy=0, done=0, hi=0, lo=0, internal A=0, Q=0, q_1=0, M=0, count=0.
- Internal registers:
  - A: WIDTH+1 bits, signed accumulator. The extra bit absorbs A-M overflow when M=-2^(WIDTH-1).
  - Q: WIDTH bits.
  - q_1: 1 bit, the Booth bit right of Q[0].
  - M: WIDTH+1 bits, sign-extended multiplicand.
  - count: CNT_W bits.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1: load M=sext(multiplicand), Q=multiplier, A=0, q_1=0, count=0; go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1), each cycle:
  - {Q[0],q_1}=01: A'=A+M.
  - {Q[0],q_1}=10: A'=A-M.
  - {Q[0],q_1}=00 or 11: A'=A.
  - Then arithmetic right shift of {A',Q,q_1} by one (A MSB replicated); count increments.
  - When count reaches WIDTH-1 during the final iteration: load hi/lo from {A[WIDTH-1:0],Q} after that shift; go to DONE.
- DONE (done=1, busy=0): lasts exactly one cycle.
  - start=1: perform the IDLE load; go to RUN. Back-to-back with no idle gap.
  - start=0: go to IDLE.
- Latency: start sampled at edge E0. Iterations occur on edges E1..E32 (WIDTH=32). done is high in the cycle after E32. Total 33 clocks from start to done.
- hi/lo: change only on entry to DONE or on reset. They hold the last product indefinitely, including through the following RUN.
- start while busy=1 is ignored; operands are not re-sampled.
- Operand inputs may change freely after the start cycle.
- Reset asserted mid-RUN: next edge returns to IDLE with all reset values, discarding the partial product. done never pulses for an aborted operation.
- Arithmetic is exact two's-complement over the full range, including -2^(WIDTH-1) for either operand. No overflow flag is produced; the full 2*WIDTH product is always exact.

Decomposition:
- Shared package/include, for reuse by the future divide sequencer:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - constant WORD_W=32.
  - Booth action codes BOOTH_NOP, BOOTH_ADD, BOOTH_SUB.
- One sub-module, booth_step: combinational single iteration.
  - Inputs: A, Q, q_1, M.
  - Outputs: next A, Q, q_1 after add/sub and arithmetic shift.
- FSM, counter and HI/LO registers stay in booth_seq_multiplier.

Test Plan:
- Basic: reset 2 cycles; start with M=3, Q=5 -> busy high 32 cycles, done pulse at cycle 33, hi=0x00000000, lo=0x0000000F.
- Mixed sign: M=-7 (0xFFFFFFF9), Q=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also M=-1, Q=-1 -> hi=0, lo=1.
- Extremes: M=0x80000000, Q=0x80000000 -> hi=0x40000000, lo=0x00000000. M=0x7FFFFFFF, Q=0x80000000 -> hi=0xC0000000, lo=0x80000000.
- Start while busy: start M=2, Q=2; pulse start with M=9, Q=9 at cycle 10 -> result 4, done exactly once, hi/lo unaffected by second request.
- Back-to-back: start held high across DONE with second operands M=6, Q=7 -> first done, RUN resumes next cycle, second done 33 cycles later with lo=42; previous hi/lo held during second RUN.
- Reset mid-operation: assert reset at cycle 15 of a RUN -> next cycle busy=0, done=0, hi=lo=0, state IDLE; no done pulse; a subsequent start produces a correct product.
